seq_arith_unit: RTL



---
 rtl/seq_arith_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: start/busy/done arithmetic engine (add, sub, shift-add mul, restoring div).
// Optional macro ARITH_SIGNED_EN: two's-complement mul/div with a sign-fixup FINISH cycle.
`default_nettype none

module seq_arith_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           module_select,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;

  state_t               state, state_nx;
  logic [2*WIDTH-1:0]   acc, iter_acc;
  logic [WIDTH-1:0]     dvs, mag_a, mag_b, rem_sub;
  logic [WIDTH:0]       mul_sum, add_sum, sub_diff;
  logic [CNT_W-1:0]     cnt;
  logic                 is_div, rem_ge, quick;

`ifdef ARITH_SIGNED_EN
  logic                 sign_a, sign_b, fix_pending;
  logic [2*WIDTH-1:0]   fixed;
`endif

  assign add_sum  = {1'b0, opA} + {1'b0, opB};
  assign sub_diff = {1'b0, opA} - {1'b0, opB};
  // Add, sub and divide-by-zero finish straight from IDLE.
  assign quick    = !module_select[1] || (module_select[0] && (opB == '0));

`ifdef ARITH_SIGNED_EN
  assign mag_a = opA[WIDTH-1] ? -opA : opA;
  assign mag_b = opB[WIDTH-1] ? -opB : opB;
`else
  assign mag_a = opA;
  assign mag_b = opB;
`endif

  // One iteration of either core; acc = {upper/remainder, multiplier/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    rem_ge   = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, dvs};
    rem_sub  = acc[2*WIDTH-2:WIDTH-1] - dvs;
    iter_acc = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (rem_ge) iter_acc = {rem_sub, acc[WIDTH-2:0], 1'b1};
      else        iter_acc = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

`ifdef ARITH_SIGNED_EN
  always_comb begin
    fixed = acc;
    if (!is_div) begin
      if (sign_a ^ sign_b) fixed = -acc;
    end else begin
      if (sign_a ^ sign_b) fixed[WIDTH-1:0] = -acc[WIDTH-1:0];
      if (sign_a)          fixed[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
    end
  end
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = quick ? FINISH : CALC;
      CALC:   if (cnt == CNT_W'(1)) state_nx = FINISH;
`ifdef ARITH_SIGNED_EN
      FINISH: state_nx = fix_pending ? FINISH : IDLE;
`else
      FINISH: state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
`ifdef ARITH_SIGNED_EN
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      fix_pending <= 1'b0;
`endif
    end else begin
      busy <= (state_nx != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          is_div      <= module_select[0];
          div_by_zero <= 1'b0;
          cnt         <= CNT_W'(WIDTH);
          acc         <= {{WIDTH{1'b0}}, mag_a};
          dvs         <= mag_b;
`ifdef ARITH_SIGNED_EN
          sign_a      <= opA[WIDTH-1];
          sign_b      <= opB[WIDTH-1];
`endif
          done        <= quick;
          case (module_select)
            2'b00:   result <= {{(WIDTH-1){1'b0}}, add_sum};
            2'b01:   result <= {{(WIDTH-1){1'b0}}, sub_diff};
            2'b11:   if (opB == '0) begin
                       result      <= {opA, {WIDTH{1'b1}}};
                       div_by_zero <= 1'b1;
                     end
            default: ;
          endcase
        end
        CALC: begin
          acc <= iter_acc;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
`ifdef ARITH_SIGNED_EN
            fix_pending <= 1'b1;
`else
            result <= iter_acc;
            done   <= 1'b1;
`endif
          end
        end
        FINISH: begin
`ifdef ARITH_SIGNED_EN
          if (fix_pending) begin
            result      <= fixed;
            done        <= 1'b1;
            fix_pending <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
